// File: rtl/aud_block_out.sv
// aud_block_out: double-buffered 16-sample block I2S DAC transmitter.
// Build option AUD_BLOCK_OUT_HOLD_EN: underrun repeats last L/R pair.
module aud_block_out #(
  parameter int N_SAMP = 16,
  parameter int W      = 16,
  parameter int CNT_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_lrc,
  input  logic [N_SAMP*W-1:0] i_blk_l,
  input  logic [N_SAMP*W-1:0] i_blk_r,
  input  logic                i_blk_valid,
  output logic                o_blk_ready,
  output logic                o_dacdat,
  output logic                o_playing,
  output logic                o_underrun,
  output logic [CNT_W-1:0]    o_underrun_cnt
);

  localparam int IW = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
  localparam int BW = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(N_SAMP - 1);
  localparam logic [BW-1:0] BMAX = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, ARM, SEND, PAD} state_t;
  state_t state;

  logic lrc_d, fall, rise, run;
  logic blk_end, ld, acc, dl;
  logic sh_full, act_valid, r_sent;
  logic [N_SAMP*W-1:0] sh_l, sh_r;
  logic [N_SAMP*W-1:0] act_l, act_r;
  logic [IW-1:0] idx, idx_n;
  logic [BW-1:0] bitcnt;
  logic [W-1:0] sreg, nw;
  logic [W-1:0] und_l, und_r;

`ifdef AUD_BLOCK_OUT_HOLD_EN
  logic [W-1:0] last_l, last_r;
  assign und_l = last_l;
  assign und_r = last_r;
`else
  assign und_l = '0;
  assign und_r = '0;
`endif

  assign fall = lrc_d & ~i_lrc;
  assign rise = ~lrc_d & i_lrc;
  assign run  = (state == SEND) || (state == PAD);

  // no live block counts as a block end, so underrun frames re-check
  assign blk_end = ~act_valid | (r_sent & (idx == LAST));
  assign idx_n   = r_sent ? idx + IW'(1) : idx;

  assign o_blk_ready = ~sh_full;
  assign acc = i_blk_valid & o_blk_ready;
  assign dl  = i_enable & run & fall & blk_end
             & ~sh_full & i_blk_valid;

  always_comb begin
    ld = 1'b0;
    nw = '0;
    if (i_enable && state == ARM && fall) begin
      ld = 1'b1;
      nw = sh_l[W-1:0];
    end else if (i_enable && run && fall) begin
      ld = 1'b1;
      if (!blk_end)
        nw = act_l[int'(idx_n)*W +: W];
      else if (sh_full)
        nw = sh_l[W-1:0];
      else if (i_blk_valid)
        nw = i_blk_l[W-1:0];
      else
        nw = und_l;
    end else if (i_enable && run && rise) begin
      ld = 1'b1;
      nw = act_valid ? act_r[int'(idx)*W +: W] : und_r;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      lrc_d          <= 1'b0;
      sh_full        <= 1'b0;
      act_valid      <= 1'b0;
      r_sent         <= 1'b0;
      idx            <= '0;
      bitcnt         <= '0;
      sreg           <= '0;
      sh_l           <= '0;
      sh_r           <= '0;
      act_l          <= '0;
      act_r          <= '0;
      o_dacdat       <= 1'b0;
      o_playing      <= 1'b0;
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
`ifdef AUD_BLOCK_OUT_HOLD_EN
      last_l         <= '0;
      last_r         <= '0;
`endif
    end else begin
      lrc_d      <= i_lrc;
      o_underrun <= 1'b0;

      if (acc && !dl) begin
        sh_l    <= i_blk_l;
        sh_r    <= i_blk_r;
        sh_full <= 1'b1;
      end

      // new word: MSB goes out the cycle after the edge
      if (ld) begin
        o_dacdat <= nw[W-1];
        sreg     <= {nw[W-2:0], 1'b0};
        bitcnt   <= BMAX;
        state    <= SEND;
      end

`ifdef AUD_BLOCK_OUT_HOLD_EN
      if (ld && fall) last_l <= nw;
      if (ld && rise) last_r <= nw;
`endif

      if (!i_enable) begin
        state     <= IDLE;
        o_dacdat  <= 1'b0;
        o_playing <= 1'b0;
        act_valid <= 1'b0;
        act_l     <= '0;
        act_r     <= '0;
        r_sent    <= 1'b0;
        idx       <= '0;
        bitcnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            o_dacdat <= 1'b0;
            if (sh_full) state <= ARM;
          end
          ARM: begin
            if (fall) begin
              act_l     <= sh_l;
              act_r     <= sh_r;
              sh_full   <= 1'b0;
              act_valid <= 1'b1;
              idx       <= '0;
              r_sent    <= 1'b0;
              o_playing <= 1'b1;
            end else begin
              o_dacdat <= 1'b0;
            end
          end
          SEND, PAD: begin
            if (fall) begin
              r_sent <= 1'b0;
              if (!blk_end) begin
                idx <= idx_n;
              end else begin
                idx <= '0;
                if (sh_full) begin
                  act_l     <= sh_l;
                  act_r     <= sh_r;
                  sh_full   <= 1'b0;
                  act_valid <= 1'b1;
                end else if (i_blk_valid) begin
                  act_l     <= i_blk_l;
                  act_r     <= i_blk_r;
                  act_valid <= 1'b1;
                end else begin
                  act_valid  <= 1'b0;
                  o_underrun <= 1'b1;
                  if (o_underrun_cnt != '1)
                    o_underrun_cnt <= o_underrun_cnt + CNT_W'(1);
                end
              end
            end else if (rise) begin
              r_sent <= 1'b1;
            end else if (state == SEND) begin
              if (bitcnt == '0) begin
                o_dacdat <= 1'b0;
                state    <= PAD;
              end else begin
                o_dacdat <= sreg[W-1];
                sreg     <= {sreg[W-2:0], 1'b0};
                bitcnt   <= bitcnt - BW'(1);
              end
            end else begin
              o_dacdat <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_block_out.sv
// tb_aud_block_out: directed checks of block handshake, I2S framing,
// underrun, same-cycle load, short LRC halves, disable and reset.
module tb_aud_block_out;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic lrc = 1'b1;
  logic bv = 1'b0;
  logic [N*W-1:0] bl = '0;
  logic [N*W-1:0] br = '0;
  logic ready, dac, playing, und;
  logic [CW-1:0] ucnt;

  int checks = 0;
  int errors = 0;
  int half = 32;
  int lcnt = 0;
  bit lrc_run = 1'b0;
  logic cur_lr = 1'b1;
  logic [15:0] wd;
  logic und_s;
  int pad_bad = 0;
  int und_tot = 0;

  aud_block_out #(.N_SAMP(N), .W(W), .CNT_W(CW)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(en),
    .i_lrc(lrc),
    .i_blk_l(bl),
    .i_blk_r(br),
    .i_blk_valid(bv),
    .o_blk_ready(ready),
    .o_dacdat(dac),
    .o_playing(playing),
    .o_underrun(und),
    .o_underrun_cnt(ucnt)
  );

  always #5 clk = ~clk;

  // LRC toggles on negedges every 'half' cycles
  initial forever begin
    @(negedge clk);
    if (lrc_run) begin
      lcnt++;
      if (lcnt >= half) begin
        lcnt = 0;
        lrc = ~lrc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic restart();
    lrc_run = 1'b0;
    lrc = 1'b1;
    lcnt = 0;
    half = 32;
    en = 1'b0;
    bv = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_lr = 1'b1;
    pad_bad = 0;
    und_tot = 0;
  endtask

  task automatic fill(input int lb, input int ls, input int rb, input int rs);
    for (int k = 0; k < N; k++) begin
      bl[k*W +: W] = 16'(lb + k*ls);
      br[k*W +: W] = 16'(rb + k*rs);
    end
  endtask

  task automatic offer(input int lb, input int ls, input int rb, input int rs);
    fill(lb, ls, rb, rs);
    bv = 1'b1;
    @(posedge clk);
    #1;
    bv = 1'b0;
  endtask

  // capture one word starting at the next LRC edge
  task automatic get_word();
    int n;
    n = 0;
    while (lrc === cur_lr && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (lrc === cur_lr) begin
        if (dac !== 1'b0) pad_bad++;
        if (und === 1'b1) und_tot++;
      end
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL lrc_wait: no LRC edge in %0d cycles", n);
    end
    cur_lr = lrc;
    und_s = und;
    wd = '0;
    wd[15] = dac;
    if (und === 1'b1) und_tot++;
    for (int i = 14; i >= 0; i--) begin
      @(posedge clk);
      #1;
      if (lrc !== cur_lr) break;
      wd[i] = dac;
      if (und === 1'b1) und_tot++;
    end
  endtask

  task automatic get_frame(output logic [15:0] l, output logic [15:0] r,
                           output logic u);
    get_word();
    if (cur_lr !== 1'b0) get_word();
    if (cur_lr !== 1'b0) get_word();
    l = wd;
    u = und_s;
    get_word();
    r = wd;
  endtask

  task automatic test_reset();
    restart();
    checks++;
    if (dac !== 1'b0) begin
      errors++; $display("FAIL reset_dacdat: got %b want 0", dac);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready);
    end
    checks++;
    if (playing !== 1'b0) begin
      errors++; $display("FAIL reset_playing: got %b want 0", playing);
    end
    checks++;
    if (und !== 1'b0) begin
      errors++; $display("FAIL reset_underrun: got %b want 0", und);
    end
    checks++;
    if (ucnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", ucnt);
    end
  endtask

  task automatic test_stream_underrun();
    logic [15:0] l, r, el, er;
    logic u;
    restart();
    offer(16'h1000, 1, 16'h2000, 1);
    en = 1'b1;
    lrc_run = 1'b1;
    for (int f = 0; f < 16; f++) begin
      get_frame(l, r, u);
      el = 16'(16'h1000 + f);
      er = 16'(16'h2000 + f);
      checks++;
      if (l !== el || r !== er || u !== 1'b0) begin
        errors++;
        $display("FAIL stream_f%0d: got %h/%h u=%b want %h/%h u=0",
                 f, l, r, u, el, er);
      end
    end
    checks++;
    if (pad_bad != 0) begin
      errors++; $display("FAIL stream_pad: %0d nonzero pad bits want 0", pad_bad);
    end
`ifdef AUD_BLOCK_OUT_HOLD_EN
    el = 16'h100F;
    er = 16'h200F;
`else
    el = 16'h0000;
    er = 16'h0000;
`endif
    get_frame(l, r, u);
    checks++;
    if (u !== 1'b1) begin
      errors++; $display("FAIL underrun_pulse17: got %b want 1", u);
    end
    checks++;
    if (ucnt !== 8'd1) begin
      errors++; $display("FAIL underrun_cnt17: got %0d want 1", ucnt);
    end
    for (int f = 17; f < 20; f++) begin
      checks++;
      if (l !== el || r !== er) begin
        errors++;
        $display("FAIL underrun_word_f%0d: got %h/%h want %h/%h",
                 f, l, r, el, er);
      end
      if (f < 19) get_frame(l, r, u);
    end
    checks++;
    if (ucnt !== 8'd3) begin
      errors++; $display("FAIL underrun_cnt19: got %0d want 3", ucnt);
    end
    checks++;
    if (und_tot != 3) begin
      errors++; $display("FAIL underrun_pulses: got %0d want 3", und_tot);
    end
    checks++;
    if (playing !== 1'b1) begin
      errors++; $display("FAIL underrun_playing: got %b want 1", playing);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l, r, el, er;
    logic u;
    restart();
    offer(16'h1000, 1, 16'h2000, 1);
    en = 1'b1;
    lrc_run = 1'b1;
    get_frame(l, r, u);
    checks++;
    if (l !== 16'h1000 || r !== 16'h2000) begin
      errors++; $display("FAIL b2b_f0: got %h/%h want 1000/2000", l, r);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_pre: got %b want 1", ready);
    end
    offer(16'h3000, 1, 16'h4000, 1);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_low: got %b want 0", ready);
    end
    for (int f = 1; f < 32; f++) begin
      get_frame(l, r, u);
      el = (f < 16) ? 16'(16'h1000 + f) : 16'(16'h3000 + f - 16);
      er = (f < 16) ? 16'(16'h2000 + f) : 16'(16'h4000 + f - 16);
      checks++;
      if (l !== el || r !== er) begin
        errors++;
        $display("FAIL b2b_f%0d: got %h/%h want %h/%h", f, l, r, el, er);
      end
      if (f == 17) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_swap: got %b want 1", ready);
        end
      end
    end
    checks++;
    if (und_tot != 0 || pad_bad != 0) begin
      errors++;
      $display("FAIL b2b_gapless: pulses=%0d pad=%0d want 0/0",
               und_tot, pad_bad);
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] l, r;
    logic u;
    int n;
    restart();
    offer(16'h1000, 1, 16'h2000, 1);
    en = 1'b1;
    lrc_run = 1'b1;
    for (int f = 0; f < 16; f++) get_frame(l, r, u);
    fill(16'h5000, 1, 16'h6000, 1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (lrc !== 1'b0 && n < 100);
    bv = 1'b1;
    @(posedge clk);
    #1;
    bv = 1'b0;
    checks++;
    if (und !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_flags: und=%b ready=%b want 0/1", und, ready);
    end
    get_frame(l, r, u);
    checks++;
    if (l !== 16'h5000 || r !== 16'h6000 || u !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_f0: got %h/%h u=%b want 5000/6000 u=0", l, r, u);
    end
    get_frame(l, r, u);
    checks++;
    if (l !== 16'h5001 || r !== 16'h6001) begin
      errors++; $display("FAIL same_cycle_f1: got %h/%h want 5001/6001", l, r);
    end
    checks++;
    if (ucnt !== 8'd0 || und_tot != 0) begin
      errors++;
      $display("FAIL same_cycle_nounder: cnt=%0d pulses=%0d want 0/0",
               ucnt, und_tot);
    end
  endtask

  task automatic test_short_half();
    logic [15:0] l, r, el, er;
    logic u;
    restart();
    half = 10;
    offer(16'h0F80, 16'h0F80, 16'hF07F, -16'sh0F80);
    en = 1'b1;
    lrc_run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      get_frame(l, r, u);
      el = 16'(16'h0F80 * (f + 1));
      er = 16'(16'hF07F - 16'h0F80 * f);
      checks++;
      if (l[15:7] !== el[15:7]) begin
        errors++;
        $display("FAIL short_l%0d: got %h want %h", f, l[15:7], el[15:7]);
      end
      checks++;
      if (r[15:7] !== er[15:7]) begin
        errors++;
        $display("FAIL short_r%0d: got %h want %h", f, r[15:7], er[15:7]);
      end
    end
    checks++;
    if (und_tot != 0) begin
      errors++; $display("FAIL short_underrun: got %0d want 0", und_tot);
    end
  endtask

  task automatic test_enable_reset();
    logic [15:0] l, r;
    logic u;
    int n;
    restart();
    offer(16'h1000, 1, 16'h2000, 1);
    en = 1'b1;
    lrc_run = 1'b1;
    get_frame(l, r, u);
    offer(16'h3000, 1, 16'h4000, 1);
    n = 0;
    while (lrc === cur_lr && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dac !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL disable_out: dac=%b playing=%b want 0/0", dac, playing);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL disable_shadow: ready=%b want 0", ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dac !== 1'b0) begin
      errors++; $display("FAIL disable_idle_dac: got %b want 0", dac);
    end
    en = 1'b1;
    cur_lr = lrc;
    get_frame(l, r, u);
    checks++;
    if (l !== 16'h3000 || r !== 16'h4000 || playing !== 1'b1) begin
      errors++;
      $display("FAIL reenable_f0: got %h/%h p=%b want 3000/4000 p=1",
               l, r, playing);
    end
    n = 0;
    while (lrc === cur_lr && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dac !== 1'b0 || ready !== 1'b1 || playing !== 1'b0 ||
        und !== 1'b0 || ucnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset: dac=%b rdy=%b p=%b u=%b cnt=%0d want 0/1/0/0/0",
               dac, ready, playing, und, ucnt);
    end
    rst_n = 1'b1;
    lrc_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream_underrun();
    test_back_to_back();
    test_same_cycle();
    test_short_half();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
